// File: rtl/theta_seq.sv
// Keccak theta step as a 4-state sequencer (IDLE -> PAR -> APPLY -> DONE); optional col_par output under THETA_COLPAR_OUT_EN.
// Latency: input handshake at edge T, out_valid high after edge T+2; one state per 3 cycles when streaming.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready in DONE, low in PAR/APPLY.

package keccak_pkg;
  // Keccak-f[1600] state, indexed [y][x][z]
  typedef logic [4:0][4:0][63:0] state;
  // column parities, indexed [x][z]
  typedef logic [4:0][63:0] colpar;
endpackage

module theta_seq (
  input  logic              clk,
  input  logic              rst_n,
  input  keccak_pkg::state  A_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output keccak_pkg::state  A_out,
`ifdef THETA_COLPAR_OUT_EN
  output keccak_pkg::colpar col_par,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, PAR, APPLY, DONE} st_t;

  st_t               st;
  keccak_pkg::state  a_reg;
  keccak_pkg::colpar c_reg;
  keccak_pkg::colpar c_next;
  keccak_pkg::state  a_next;

  // Column parity of the captured state: XOR down each column over y.
  for (genvar x = 0; x < 5; x++) begin : g_par_x
    for (genvar z = 0; z < 64; z++) begin : g_par_z
      assign c_next[x][z] = a_reg[0][x][z] ^ a_reg[1][x][z] ^ a_reg[2][x][z]
                          ^ a_reg[3][x][z] ^ a_reg[4][x][z];
    end
  end

  // Theta mix: left-neighbour column parity plus right-neighbour parity one lane bit lower.
  // Neighbour indices are constant modulo offsets, so wrap needs no comparison logic.
  for (genvar y = 0; y < 5; y++) begin : g_th_y
    for (genvar x = 0; x < 5; x++) begin : g_th_x
      for (genvar z = 0; z < 64; z++) begin : g_th_z
        assign a_next[y][x][z] = a_reg[y][x][z]
                               ^ c_reg[(x + 4) % 5][z]
                               ^ c_reg[(x + 1) % 5][(z + 63) % 64];
      end
    end
  end

  // Accept in IDLE, or in DONE exactly when the current result is being drained.
  assign in_ready = (st == IDLE) || ((st == DONE) && out_ready);

`ifdef THETA_COLPAR_OUT_EN
  assign col_par = c_reg;
`endif

  // Sequencer: state, datapath registers and registered out_valid/busy; flush beats any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      a_reg     <= '0;
      c_reg     <= '0;
      A_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      st        <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A_in;
            st    <= PAR;
            busy  <= 1'b1;
          end
        end
        PAR: begin
          c_reg <= c_next;
          st    <= APPLY;
        end
        APPLY: begin
          A_out     <= a_next;
          out_valid <= 1'b1;
          st        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg <= A_in;
              st    <= PAR;
            end else begin
              st    <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_theta_seq.sv
// Randomized bench for theta_seq against a lane-level theta model.
// Latency: checks out_valid 3 edges after the accepting edge (handshake edge counted as 1).
// Backpressure: random out_ready stalls, streaming, flush and mid-flight reset.
module tb_theta_seq;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  keccak_pkg::state  A_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              flush = 1'b0;
  keccak_pkg::state  A_out;
`ifdef THETA_COLPAR_OUT_EN
  keccak_pkg::colpar col_par;
`endif
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  theta_seq dut (
    .clk(clk), .rst_n(rst_n), .A_in(A_in), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .A_out(A_out),
`ifdef THETA_COLPAR_OUT_EN
    .col_par(col_par),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Compare and, on mismatch, report the first differing 64-bit lane.
  task automatic chk(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      for (int i = 0; i < 25; i++) begin
        if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h", tag, i, got[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
      end
    end
  endtask

  // Column parity lanes: each lane is the XOR of the five lanes of its column.
  function automatic keccak_pkg::colpar ref_par(input keccak_pkg::state a);
    keccak_pkg::colpar c;
    for (int x = 0; x < 5; x++) begin
      c[x] = a[0][x] ^ a[1][x] ^ a[2][x] ^ a[3][x] ^ a[4][x];
    end
    return c;
  endfunction

  // Theta: D[x] = C[x-1] ^ ROTL(C[x+1], 1), added to every lane of column x.
  function automatic keccak_pkg::state ref_theta(input keccak_pkg::state a);
    keccak_pkg::colpar c;
    keccak_pkg::state  r;
    logic [63:0]       d;
    logic [63:0]       cr;
    c = ref_par(a);
    for (int x = 0; x < 5; x++) begin
      cr = c[(x + 1) % 5];
      d  = c[(x + 4) % 5] ^ {cr[62:0], cr[63]};
      for (int y = 0; y < 5; y++) r[y][x] = a[y][x] ^ d;
    end
    return r;
  endfunction

  function automatic keccak_pkg::state rnd_state();
    logic [1599:0] v;
    for (int i = 0; i < 50; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transform from IDLE, then hold out_ready low for 'stall' cycles and drain.
  task automatic xform(input keccak_pkg::state a, input int stall, input string tag);
    keccak_pkg::state exp;
    int n;
    exp       = ref_theta(a);
    out_ready = 1'b0;
    A_in      = a;
    in_valid  = 1'b1;
    chk({tag, ".in_ready_idle"}, in_ready, 1);
    n = 0;
    do begin
      step();
      n++;
      in_valid = 1'b0;
      if (n == 1) chk({tag, ".busy"}, busy, 1);
    end while (!out_valid && n < 20);
    chk({tag, ".latency"}, n, 3);
    chk({tag, ".A_out"}, A_out, exp);
`ifdef THETA_COLPAR_OUT_EN
    chk({tag, ".col_par"}, col_par, ref_par(a));
`endif
    for (int i = 0; i < stall; i++) begin
      step();
      chk({tag, ".stall_vld"}, out_valid, 1);
      chk({tag, ".stall_dat"}, A_out, exp);
      chk({tag, ".stall_rdy"}, in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready_done"}, in_ready, 1);
    step();
    out_ready = 1'b0;
    chk({tag, ".drain_vld"}, out_valid, 0);
    chk({tag, ".drain_busy"}, busy, 0);
  endtask

  initial begin
    keccak_pkg::state a, b, last;
    logic [8:0] vld_seen;

    // reset state
    #3;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.A_out", A_out, 0);
    chk("rst.in_ready", in_ready, 1);
`ifdef THETA_COLPAR_OUT_EN
    chk("rst.col_par", col_par, 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // directed patterns
    xform('0, 0, "zero");
    a = '0;
    a[0][0][0] = 1'b1;
    xform(a, 1, "onebit");
    chk("onebit.popcount", $countones(A_out), 11);
    chk("onebit.y4x4z1", A_out[4][4][1], 1);
    chk("onebit.y3x1z0", A_out[3][1][0], 1);
`ifdef THETA_COLPAR_OUT_EN
    b = '0;
    b[0][0][0] = 1'b1;
    chk("onebit.col_par", col_par, b[0]);
`endif
    xform('1, 2, "ones");
    chk("ones.all", A_out, '1);

    // random states with random backpressure
    for (int i = 0; i < 8; i++) begin
      xform(rnd_state(), int'($urandom_range(0, 4)), "rand");
    end

    // long stall
    a = rnd_state();
    xform(a, 10, "stall10");
    last = ref_theta(a);

    // back-to-back streaming with in_valid held
    a = rnd_state();
    b = rnd_state();
    out_ready = 1'b1;
    A_in      = a;
    in_valid  = 1'b1;
    vld_seen  = '0;
    for (int n = 1; n <= 8; n++) begin
      step();
      vld_seen[n] = out_valid;
      if (n == 3) begin
        chk("stream.first", A_out, ref_theta(a));
        A_in = b;
      end
      if (n == 4) begin
        in_valid = 1'b0;
        chk("stream.busy", busy, 1);
      end
      if (n == 6) chk("stream.second", A_out, ref_theta(b));
    end
    chk("stream.vld_pattern", vld_seen, 9'b0_0100_1000);
    last = ref_theta(b);
    out_ready = 1'b0;

    // flush during APPLY
    A_in     = rnd_state();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush.out_valid", out_valid, 0);
    chk("flush.busy", busy, 0);
    chk("flush.in_ready", in_ready, 1);
    chk("flush.A_out_kept", A_out, last);
    vld_seen = '0;
    for (int n = 0; n < 4; n++) begin
      step();
      vld_seen[n] = out_valid;
    end
    chk("flush.no_vld", vld_seen, 0);

    // reset mid-APPLY
    A_in     = rnd_state();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst.A_out", A_out, 0);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.busy", busy, 0);
`ifdef THETA_COLPAR_OUT_EN
    chk("midrst.col_par", col_par, 0);
`endif
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst.in_ready", in_ready, 1);
    xform(rnd_state(), 1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // watchdog so the run always reaches a verdict
  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
